pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage pipeline. Merges per-stage stall
//  requests into the monotonic stall[STAGE_NUM-1:0] vector consumed by every pipeline
//  register (if_id, id_ex, ex_mem, mem_wb). Generates front-end kill on taken branches,
//  full-pipe flush on traps, and PC redirect. Deferred redirect when fetch is busy; stall perf counter.
// PARAMETERS
//  TRAP_VEC   32'h0000_0000  redirect PC on trap
//  CNT_W      32             width of stall-cycle counter
// PORTS
//  clk           in   1      clock
//  rstn          in   1      async active-low reset
//  if_stall_req  in   1      instruction memory not ready
//  id_stall_req  in   1      load-use hazard detected in ID
//  ex_stall_req  in   1      multi-cycle EX op busy
//  me_stall_req  in   1      data memory not ready
//  br_taken      in   1      EX resolved taken branch/jump
//  br_target     in   32     branch target PC
//  trap_req      in   1      trap/exception raised (any stage)
//  stall         out  STAGE_NUM  per-stage hold, Stop=1, bit index = cpu_pkg stage index
//  kill_front    out  1      bubble IF/ID and ID/EX
//  flush         out  1      clear all pipeline registers
//  redirect_vld  out  1      load redirect_pc into PC
//  redirect_pc   out  32     new PC
//  stall_cnt     out  CNT_W  cycles with stall[IF_STAGE]==Stop, saturating
// BEHAVIOUR
//  Reset (async, rstn=0): state=RUN, stall=0, kill_front=0, flush=0, redirect_vld=0,
//   redirect_pc=0, stall_cnt=0, pending target cleared. Reset mid-operation discards all.
//  Stall vector (combinational): k = highest stage with active request (IF=0,ID=1,EX=2,ME=3);
//   stall[0..k]=Stop, above k NoStop. stall[WB_STAGE] always NoStop. No request -> all NoStop.
//   In BR_WAIT, stall[IF_STAGE] and stall[ID_STAGE] additionally forced Stop.
//  Branch acceptance: br_taken honoured only when stall[EX_STAGE]==NoStop; otherwise ignored
//   (EX holds, br_taken re-presented next cycle by held EX instruction).
//  FSM states RUN, BR_WAIT, TRAP (typedef ctrl_state_e):
//   RUN: trap_req -> TRAP. Else accepted br_taken & ~if_stall_req -> same cycle
//    kill_front=1, redirect_vld=1, redirect_pc=br_target, stay RUN.
//    Accepted br_taken & if_stall_req -> latch br_target, -> BR_WAIT (no redirect yet).
//   BR_WAIT: trap_req -> TRAP (pending branch discarded). ~if_stall_req -> that cycle
//    kill_front=1, redirect_vld=1, redirect_pc=latched target, -> RUN. Else stay.
//   TRAP: flush=1, redirect_vld=1, redirect_pc=TRAP_VEC for exactly one cycle (cycle after
//    trap_req sampled), stall forced all NoStop, -> RUN. trap_req in TRAP is ignored.
//  flush is registered (1-cycle latency from trap_req); kill_front/redirect in RUN/BR_WAIT are
//   combinational (0-cycle). Trap beats branch when simultaneous. flush and kill_front never
//   both 1 in one cycle.
//  stall_cnt: +1 each cycle stall[IF_STAGE]==Stop; holds at 2^CNT_W-1 (no wrap).
// STRUCTURE
//  cpu_pkg: add ctrl_state_e {RUN,BR_WAIT,TRAP}; reuse STAGE_NUM, IF/ID/EX/ME/WB_STAGE,
//   Stop/NoStop, ZeroWord; add function stall_vec(reqs) returning the monotonic vector.
//  Single module, no sub-modules; one always_ff for state/target/counter, one always_comb
//   for stall/kill/redirect.
// TESTING
//  me_stall_req=1 only -> stall=5'b01111, mem_wb receives bubble; drop -> stall=0 next cycle.
//  id_stall_req=1 & me_stall_req=1 -> stall=5'b01111; id_stall_req only -> 5'b00011.
//  br_taken=1, br_target=32'h100, no stalls -> same cycle kill_front=1, redirect_pc=32'h100.
//  br_taken with if_stall_req=1 for 3 cycles -> BR_WAIT, stall[1:0]=2'b11, redirect 32'h100
//   on the cycle if_stall_req drops, kill_front=1 that cycle only.
//  trap_req and br_taken same cycle -> next cycle flush=1, redirect_pc=TRAP_VEC, no kill_front.
//  Force stall 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt=15 saturated; rstn pulse mid-BR_WAIT
//   -> all outputs 0, no redirect after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: stage indices, stall polarity and the controller state type.
// stall_vec turns per-stage stall requests into the monotonic hold vector.
package cpu_pkg;

  localparam int STAGE_NUM = 5;
  localparam int IF_STAGE  = 0;
  localparam int ID_STAGE  = 1;
  localparam int EX_STAGE  = 2;
  localparam int ME_STAGE  = 3;
  localparam int WB_STAGE  = 4;

  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    TRAP    = 2'd2
  } ctrl_state_e;

  // A stage must hold whenever it or any later stage (up to ME) is requesting a stall.
  function automatic logic [STAGE_NUM-1:0] stall_vec(input logic [3:0] reqs);
    logic [STAGE_NUM-1:0] v;
    v = {STAGE_NUM{NoStop}};
    for (int i = 0; i < 4; i++) begin
      if (|(reqs >> i)) begin
        v[i] = Stop;
      end else begin
        v[i] = NoStop;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, front-end kill, trap flush, PC redirect
// (deferred while fetch is busy) and a saturating fetch-stall cycle counter.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 if_stall_req,
  input  logic                 id_stall_req,
  input  logic                 ex_stall_req,
  input  logic                 me_stall_req,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 trap_req,
  output logic [STAGE_NUM-1:0] stall,
  output logic                 kill_front,
  output logic                 flush,
  output logic                 redirect_vld,
  output logic [31:0]          redirect_pc,
  output logic [CNT_W-1:0]     stall_cnt
);

  ctrl_state_e      state_q, state_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_acc_s;

  // Stall/kill/redirect decode and next-state for state, pending target and counter.
  always_comb begin
    stall        = stall_vec({me_stall_req, ex_stall_req, id_stall_req, if_stall_req});
    // A held EX stage will re-present its branch, so only take it when EX advances.
    br_acc_s     = br_taken & (stall[EX_STAGE] == NoStop);
    kill_front   = 1'b0;
    flush        = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = ZeroWord;
    state_d      = state_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;

    case (state_q)
      RUN: begin
        if (trap_req) begin
          state_d = TRAP;
        end else if (br_acc_s && !if_stall_req) begin
          kill_front   = 1'b1;
          redirect_vld = 1'b1;
          redirect_pc  = br_target;
          state_d      = RUN;
        end else if (br_acc_s) begin
          tgt_d   = br_target;
          state_d = BR_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      BR_WAIT: begin
        stall[IF_STAGE] = Stop;
        stall[ID_STAGE] = Stop;
        if (trap_req) begin
          tgt_d   = ZeroWord;
          state_d = TRAP;
        end else if (!if_stall_req) begin
          kill_front   = 1'b1;
          redirect_vld = 1'b1;
          redirect_pc  = tgt_q;
          tgt_d        = ZeroWord;
          state_d      = RUN;
        end else begin
          state_d = BR_WAIT;
        end
      end
      TRAP: begin
        stall        = {STAGE_NUM{NoStop}};
        flush        = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = TRAP_VEC;
        tgt_d        = ZeroWord;
        state_d      = RUN;
      end
      default: begin
        state_d = RUN;
        tgt_d   = ZeroWord;
      end
    endcase

    if ((stall[IF_STAGE] == Stop) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Controller state, pending branch target and stall counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      tgt_q   <= ZeroWord;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule
